// File: rtl/adt_i2c_target.sv
// I2C target emulating an ADT7420-style temperature sensor with a pointer-addressed register map.
// Optional feature macro: ADT_TGT_AUTOINC_EN (pointer auto-increment after each data byte).
module adt_i2c_target #(
  parameter logic [6:0]  TGT_ADDR = 7'h4B,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] temp_in,
  input  logic        scl,
  inout  tri          sda,
  output logic [7:0]  config_q,
  output logic        cfg_wr,
  output logic        busy
);

  localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_IGNORE,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } state_e;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        filt_q, filt_d, filt_dly_q;
  logic [FCNT_W-1:0] fcnt_q [2];
  logic [FCNT_W-1:0] fcnt_d [2];

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  config_d;
  logic [15:0] shadow_q, shadow_d;
  logic        first_byte_q, first_byte_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        cfg_wr_c;

  logic       scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0] rx_byte_c, rd_data_c;

  assign sda    = sda_oe_q ? 1'b0 : 1'bz;
  assign busy   = busy_q;
  assign cfg_wr = cfg_wr_c;

  // Stability filter: a new level is accepted after FILT_LEN consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCNT_W'(FILT_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign scl_rise_c = filt_q[0] & ~filt_dly_q[0];
  assign scl_fall_c = ~filt_q[0] & filt_dly_q[0];
  assign start_c    = filt_dly_q[1] & ~filt_q[1] & filt_q[0] & filt_dly_q[0];
  assign stop_c     = ~filt_dly_q[1] & filt_q[1] & filt_q[0] & filt_dly_q[0];
  assign rx_byte_c  = {shreg_q, filt_q[1]};

  always_comb begin
    rd_data_c = 8'h00;
    case (ptr_q)
      8'h00:   rd_data_c = shadow_q[15:8];
      8'h01:   rd_data_c = shadow_q[7:0];
      8'h02:   rd_data_c = 8'h00;
      8'h03:   rd_data_c = config_q;
      8'h0B:   rd_data_c = 8'hCB;
      default: rd_data_c = 8'h00;
    endcase
  end

  // Protocol FSM; START/STOP override every state
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    sda_oe_d     = sda_oe_q;
    ptr_d        = ptr_q;
    config_d     = config_q;
    shadow_d     = shadow_q;
    first_byte_d = first_byte_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    cfg_wr_c     = 1'b0;

    if (start_c) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      shadow_d  = temp_in;
      busy_d    = 1'b0;
    end else if (stop_c) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: sda_oe_d = 1'b0;

        ST_ADDR: if (scl_rise_c) begin
          shreg_d   = rx_byte_c[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            rw_d      = filt_q[1];
            state_d   = (rx_byte_c[7:1] == TGT_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          end
        end

        // First falling edge asserts ACK, second releases it and starts the data phase
        ST_ADDR_ACK: if (scl_fall_c) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end else if (rw_q) begin
            shreg_d   = rd_data_c[6:0];
            sda_oe_d  = ~rd_data_c[7];
            bit_cnt_d = 4'd0;
            state_d   = ST_RD_BYTE;
          end else begin
            sda_oe_d     = 1'b0;
            first_byte_d = 1'b1;
            bit_cnt_d    = 4'd0;
            state_d      = ST_WR_BYTE;
          end
        end

        ST_WR_BYTE: if (scl_rise_c) begin
          shreg_d   = rx_byte_c[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_WR_ACK;
            if (first_byte_q) begin
              ptr_d        = rx_byte_c;
              first_byte_d = 1'b0;
            end else begin
              if (ptr_q == 8'h03) begin
                config_d = rx_byte_c;
                cfg_wr_c = 1'b1;
              end
`ifdef ADT_TGT_AUTOINC_EN
              ptr_d = ptr_q + 8'd1;
`endif
            end
          end
        end

        ST_WR_ACK: if (scl_fall_c) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
`ifdef ADT_TGT_AUTOINC_EN
              ptr_d = ptr_q + 8'd1;
`endif
            end else begin
              shreg_d  = {shreg_q[5:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end

        // bit_cnt marks that the master's ACK rise has been seen
        ST_RD_ACK: begin
          if (scl_rise_c) begin
            if (filt_q[1]) begin
              state_d = ST_IGNORE;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall_c && (bit_cnt_q != 4'd0)) begin
            shreg_d   = rd_data_c[6:0];
            sda_oe_d  = ~rd_data_c[7];
            bit_cnt_d = 4'd0;
            state_d   = ST_RD_BYTE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      filt_q       <= 2'b11;
      filt_dly_q   <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= 7'd0;
      sda_oe_q     <= 1'b0;
      ptr_q        <= 8'h00;
      config_q     <= 8'h00;
      shadow_q     <= 16'h0000;
      first_byte_q <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= {sda, scl};
      sync2_q      <= sync1_q;
      filt_q       <= filt_d;
      filt_dly_q   <= filt_q;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      sda_oe_q     <= sda_oe_d;
      ptr_q        <= ptr_d;
      config_q     <= config_d;
      shadow_q     <= shadow_d;
      first_byte_q <= first_byte_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_adt_i2c_target.sv
// Bench for adt_i2c_target: bus-master tasks push expectations; a monitor process pops and compares.
`timescale 1ns/1ps
module tb_adt_i2c_target;

  localparam int unsigned Q    = 20;
  localparam int unsigned FILT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] temp_in;
  logic        scl;
  logic        m_sda;
  wire         sda;
  logic [7:0]  config_q;
  logic        cfg_wr;
  logic        busy;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  adt_i2c_target #(.TGT_ADDR(7'h4B), .FILT_LEN(FILT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .temp_in  (temp_in),
    .scl      (scl),
    .sda      (sda),
    .config_q (config_q),
    .cfg_wr   (cfg_wr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cfg_cnt = 0;
  always @(posedge clk) if (cfg_wr) cfg_cnt <= cfg_cnt + 1;

  string       exp_name_q[$];
  logic [15:0] exp_val_q[$];
  logic [15:0] obs_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic exp_push(input string nm, input logic [15:0] v);
    exp_name_q.push_back(nm);
    exp_val_q.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    obs_q.push_back(v);
  endtask

  initial begin : monitor
    logic [15:0] act, ev;
    string nm;
    forever begin
      @(posedge clk);
      while (obs_q.size() > 0) begin
        act = obs_q.pop_front();
        n_checks++;
        if (exp_val_q.size() == 0) begin
          $display("FAIL unexpected_obs: got 0x%0h, no expectation queued", act);
        end else begin
          nm = exp_name_q.pop_front();
          ev = exp_val_q.pop_front();
          if (act === ev) n_pass++;
          else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, ev);
        end
      end
    end
  end

  function automatic logic bus_lvl();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(Q);
    scl   = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    scl   = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(Q);
    scl   = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic r);
    m_sda = b; wq(Q);
    scl = 1'b1; wq(Q / 2);
    if (glitch) begin
      scl = 1'b0; wq(FILT - 1);
      scl = 1'b1;
    end
    wq(Q / 2);
    r = bus_lvl();
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch_bit == i, r);
    clk_bit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    clk_bit(~ack, 1'b0, r);
  endtask

  task automatic wr_chk(input string nm, input logic [7:0] d, input logic exp_ack);
    logic a;
    exp_push(nm, 16'(exp_ack));
    write_byte(d, -1, a);
    observe(16'(a));
  endtask

  task automatic rd_chk(input string nm, input logic ack, input logic [7:0] exp_d);
    logic [7:0] d;
    exp_push(nm, 16'(exp_d));
    read_byte(ack, d);
    observe(16'(d));
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic       a, r;
    int         base;
    logic [7:0] second;
    scl = 1'b1; m_sda = 1'b1; temp_in = 16'h1234; reset_n = 1'b0;
    wq(10);
    exp_push("rst_config_q", 16'h0000); observe(16'(config_q));
    exp_push("rst_cfg_wr", 16'h0000);   observe(16'(cfg_wr));
    exp_push("rst_busy", 16'h0000);     observe(16'(busy));
    exp_push("rst_sda", 16'h0001);      observe(16'(bus_lvl()));
    reset_n = 1'b1;
    wq(20);

    // ID register read through a repeated START
    bus_start();
    wr_chk("id_ack_addr", 8'h96, 1'b1);
    wr_chk("id_ack_ptr", 8'h0B, 1'b1);
    bus_start();
    wr_chk("id_ack_raddr", 8'h97, 1'b1);
    rd_chk("id_data", 1'b0, 8'hCB);
    exp_push("id_busy_before_stop", 16'h0001); observe(16'(busy));
    bus_stop(); wq(20);
    exp_push("id_busy_after_stop", 16'h0000); observe(16'(busy));

    // Two-byte temperature read; temp_in changes mid-burst to prove shadow coherence
    temp_in = 16'h0C80;
    bus_start();
    wr_chk("tmp_ack_addr", 8'h96, 1'b1);
    wr_chk("tmp_ack_ptr", 8'h00, 1'b1);
    bus_start();
    wr_chk("tmp_ack_raddr", 8'h97, 1'b1);
    rd_chk("tmp_msb", 1'b1, 8'h0C);
    temp_in = 16'hFFFF;
`ifdef ADT_TGT_AUTOINC_EN
    second = 8'h80;
`else
    second = 8'h0C;
`endif
    rd_chk("tmp_second", 1'b0, second);
    bus_stop(); wq(20);

    // Wrong address 0x48: no ACK, no busy, trailing bytes ignored
    base = cfg_cnt;
    bus_start();
    wr_chk("mis_nack_addr", 8'h90, 1'b0);
    exp_push("mis_busy", 16'h0000); observe(16'(busy));
    wr_chk("mis_nack_b1", 8'h03, 1'b0);
    wr_chk("mis_nack_b2", 8'h55, 1'b0);
    bus_stop(); wq(20);
    exp_push("mis_cfg_pulses", 16'h0000); observe(16'(cfg_cnt - base));
    exp_push("mis_config_q", 16'h0000);   observe(16'(config_q));

    // Config register write and read-back
    base = cfg_cnt;
    bus_start();
    wr_chk("cfg_ack_addr", 8'h96, 1'b1);
    wr_chk("cfg_ack_ptr", 8'h03, 1'b1);
    wr_chk("cfg_ack_data", 8'h80, 1'b1);
    bus_stop(); wq(20);
    exp_push("cfg_pulses", 16'h0001);  observe(16'(cfg_cnt - base));
    exp_push("cfg_config_q", 16'h0080); observe(16'(config_q));
    bus_start();
    wr_chk("cfgrb_ack_addr", 8'h96, 1'b1);
    wr_chk("cfgrb_ack_ptr", 8'h03, 1'b1);
    bus_start();
    wr_chk("cfgrb_ack_raddr", 8'h97, 1'b1);
    rd_chk("cfgrb_data", 1'b0, 8'h80);
    bus_stop(); wq(20);

    // Short SCL low glitch inside the address byte must not shift a bit
    bus_start();
    exp_push("glt_ack_addr", 16'h0001);
    write_byte(8'h96, 4, a);
    observe(16'(a));
    wr_chk("glt_ack_ptr", 8'h0B, 1'b1);
    bus_start();
    wr_chk("glt_ack_raddr", 8'h97, 1'b1);
    rd_chk("glt_data", 1'b0, 8'hCB);
    bus_stop(); wq(20);

    // Reset while the target drives a zero data bit
    temp_in = 16'h0000;
    bus_start();
    wr_chk("rst_tx_ack_addr", 8'h96, 1'b1);
    wr_chk("rst_tx_ack_ptr", 8'h00, 1'b1);
    bus_start();
    wr_chk("rst_tx_ack_raddr", 8'h97, 1'b1);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0, r);
    m_sda = 1'b1; wq(Q);
    scl = 1'b1; wq(Q / 2);
    exp_push("rst_bit3_driven_low", 16'h0000); observe(16'(bus_lvl()));
    reset_n = 1'b0;
    wq(1);
    exp_push("rst_sda_released", 16'h0001); observe(16'(bus_lvl()));
    exp_push("rst_mid_config_q", 16'h0000); observe(16'(config_q));
    exp_push("rst_mid_busy", 16'h0000);     observe(16'(busy));
    wq(5);
    reset_n = 1'b1;
    wq(Q);
    scl = 1'b0; wq(Q);
    bus_stop(); wq(20);
    bus_start();
    wr_chk("post_ack_addr", 8'h96, 1'b1);
    wr_chk("post_ack_ptr", 8'h0B, 1'b1);
    bus_start();
    wr_chk("post_ack_raddr", 8'h97, 1'b1);
    rd_chk("post_data", 1'b0, 8'hCB);
    bus_stop(); wq(20);
    exp_push("post_busy", 16'h0000); observe(16'(busy));

    for (int k = 0; k < 100 && obs_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_val_q.size() != 0) begin
      $display("FAIL unobserved: got %0d observations missing, required 0", exp_val_q.size());
      n_checks = n_checks + exp_val_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
